signed_divide_iter: RTL
=======================

// Module: signed_divide_iter
// PURPOSE
//  Iterative signed restoring divider core. Consumes one shifted partial remainder per clock (shift-in of next
//  dividend magnitude bit), trial-subtracts the divisor magnitude, and retires one quotient bit per cycle.
//  Sits between the operand-issue logic and the result writeback; start/busy/done handshake, one op in flight.
// PARAMETERS
//  WIDTH  32  operand/result width in bits, two's complement; legal range 4..64
// PORTS
//  clk           in   1      single clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      request; sampled only in IDLE
//  dividend      in   WIDTH  signed N, sampled with start
//  divisor       in   WIDTH  signed D, sampled with start
//  busy          out  1      high in CALC and FIX
//  done          out  1      one-cycle pulse; results valid from this cycle
//  quotient      out  WIDTH  signed Q, truncated toward zero
//  remainder     out  WIDTH  signed R, sign follows dividend; N = Q*D + R
//  div_by_zero   out  1      set with done when D==0; cleared on next accepted start
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; internal regs 0.
//  - States: IDLE -> CALC -> FIX -> DONE -> IDLE. DONE lasts exactly 1 cycle (done=1), then IDLE unconditionally.
//  - IDLE, start=1, D!=0: latch |N|, |D| (WIDTH-bit unsigned; |-2^(W-1)| = 2^(W-1) fits), sign_q=N[W-1]^D[W-1],
//    sign_r=N[W-1]; clear partial remainder (WIDTH+1 bits) and count; -> CALC.
//  - IDLE, start=1, D==0: quotient=all ones, remainder=dividend, div_by_zero=1; -> DONE (done 1 edge after start).
//  - CALC, per cycle i=0..WIDTH-1: P' = {P[W-1:0], magN[W-1-i]}; if P' >= magD then P=P'-magD, q[W-1-i]=1
//    else P=P', q bit=0. Exactly WIDTH cycles; counter is $clog2(WIDTH)+1 bits, no wrap.
//  - FIX (1 cycle): quotient = sign_q ? -q : q; remainder = sign_r ? -P : P (mod 2^WIDTH). -> DONE.
//  - Latency: done high W+2 edges after the start-sampling edge (34 for WIDTH=32). Throughput 1 op / W+3 cycles.
//  - Overflow -2^(W-1) / -1: quotient wraps to -2^(W-1), remainder 0; no flag.
//  - start outside IDLE (incl. DONE) ignored, no queuing; operand changes after sampling have no effect.
//  - quotient/remainder/div_by_zero hold stable from DONE until the next accepted start updates them at FIX/DONE.
//  - Reset asserted mid-operation: immediate return to IDLE, outputs per reset values, no done pulse.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined: in IDLE, if D!=0 and |N| < |D|, skip CALC: q=0, P=|N| -> FIX -> DONE
//    (done 2 edges after start); results identical to full path.
//  DIV_EARLY_OUT_EN undefined: every nonzero-divisor op takes full CALC, fixed W+2 latency.
// STRUCTURE
//  - div_pkg: DIV_WIDTH default, state enum (ST_IDLE, ST_CALC, ST_FIX, ST_DONE), abs/negate helper functions.
//  - Sub-module div_restore_step (combinational): inputs P, magD, next bit; outputs P_next, q_bit.
//    Instantiated once in CALC datapath; top holds FSM, counter, sign regs, result regs.
// TESTING
//  - 100 / 7 -> Q=14, R=2, div_by_zero=0, done exactly 34 cycles after start, busy high 33 cycles.
//  - -100 / 7 -> Q=-14 (0xFFFFFFF2), R=-2; 100 / -7 -> Q=-14, R=2; -100 / -7 -> Q=14, R=-2.
//  - 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0; 0x80000000 / 1 -> Q=0x80000000, R=0.
//  - 5 / 0 -> Q=0xFFFFFFFF, R=5, div_by_zero=1, done 1 cycle after start; next 9/3 clears flag, Q=3, R=0.
//  - start with 50/5 at CALC cycle 10 of a 1000/3 op -> ignored, 1000/3 yields Q=333, R=1; then rst_n=0 mid-CALC
//    of 7/2 -> busy=0, done never pulses, Q=R=0.
//  - DIV_EARLY_OUT_EN: 3 / 10 -> Q=0, R=3 done 2 cycles after start; without macro same results at 34 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative signed divider:
//   DIV_WIDTH    default operand/result width
//   div_state_e  controller states (IDLE -> CALC -> FIX -> DONE)
//   div_negate   two's complement negation on a 64-bit container
//   div_abs      conditional negation (magnitude of a two's complement value)
// Callers zero-extend WIDTH-bit values into 64 bits and truncate the result back
// to WIDTH bits; the low WIDTH bits are then the negation modulo 2^WIDTH.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic [63:0] div_negate(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  function automatic logic [63:0] div_abs(input logic [63:0] v, input logic neg);
    logic [63:0] r;
    if (neg) begin
      r = div_negate(v);
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// -----------------------------------------------------------------------------
// div_restore_step
// One combinational restoring-division step: shift the next dividend magnitude
// bit into the partial remainder, trial-subtract the divisor magnitude, keep the
// difference when it is non-negative.
// Ports:
//   p        in   WIDTH+1  current partial remainder (always < mag_d)
//   mag_d    in   WIDTH    divisor magnitude (nonzero)
//   next_bit in   1        next dividend magnitude bit, MSB first
//   p_next   out  WIDTH+1  updated partial remainder
//   q_bit    out  1        retired quotient bit
// -----------------------------------------------------------------------------
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] mag_d,
  input  logic             next_bit,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] mag_d_ext_s;

  assign shifted_s   = {p, next_bit};
  assign mag_d_ext_s = {2'b00, mag_d};

  // Trial subtraction; the difference always fits WIDTH+1 bits because p < mag_d.
  always_comb begin
    if (shifted_s >= mag_d_ext_s) begin
      p_next = (WIDTH+1)'(shifted_s - mag_d_ext_s);
      q_bit  = 1'b1;
    end else begin
      p_next = shifted_s[WIDTH:0];
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/signed_divide_iter.sv
// -----------------------------------------------------------------------------
// signed_divide_iter
// Iterative signed restoring divider, one quotient bit per clock, one op in
// flight. Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, sampled only in IDLE
//   dividend, divisor   signed operands, sampled with an accepted start
//   busy                high in CALC and FIX
//   done                one-cycle pulse, results valid from this cycle
//   quotient, remainder signed results, held until the next accepted op
//   div_by_zero         set with done when divisor was zero
// Configuration macro: DIV_EARLY_OUT_EN -- when defined, ops with
// |dividend| < |divisor| skip CALC and go straight to FIX.
// -----------------------------------------------------------------------------
module signed_divide_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] mag_n_q, mag_n_d;   // dividend magnitude, shifted left as bits are consumed
  logic [WIDTH-1:0] mag_d_q, mag_d_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH:0]   p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] abs_n_s, abs_d_s;
  logic [WIDTH:0]   step_p_s;
  logic             step_q_s;

  assign abs_n_s = WIDTH'(div_abs(64'(dividend), dividend[WIDTH-1]));
  assign abs_d_s = WIDTH'(div_abs(64'(divisor), divisor[WIDTH-1]));

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .p        (p_q),
    .mag_d    (mag_d_q),
    .next_bit (mag_n_q[WIDTH-1]),
    .p_next   (step_p_s),
    .q_bit    (step_q_s)
  );

  // Next-state, datapath and output-register logic for the divider controller.
  always_comb begin
    state_d     = state_q;
    mag_n_d     = mag_n_q;
    mag_d_d     = mag_d_q;
    sign_q_d    = sign_q_q;
    sign_r_d    = sign_r_q;
    p_d         = p_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (divisor == {WIDTH{1'b0}}) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = ST_DONE;
          end else begin
            mag_n_d  = abs_n_s;
            mag_d_d  = abs_d_s;
            sign_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_d = dividend[WIDTH-1];
            p_d      = {(WIDTH+1){1'b0}};
            q_d      = {WIDTH{1'b0}};
            cnt_d    = {CW{1'b0}};
            dbz_d    = 1'b0;
            state_d  = ST_CALC;
`ifdef DIV_EARLY_OUT_EN
            // Quotient is zero and the remainder magnitude is |N|: only the sign fix-up remains.
            if (abs_n_s < abs_d_s) begin
              p_d     = {1'b0, abs_n_s};
              state_d = ST_FIX;
            end else begin
              state_d = ST_CALC;
            end
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        p_d     = step_p_s;
        q_d     = {q_q[WIDTH-2:0], step_q_s};
        mag_n_d = {mag_n_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_FIX: begin
        // Negation modulo 2^WIDTH makes -2^(W-1) / -1 wrap to -2^(W-1).
        quotient_d  = sign_q_q ? WIDTH'(div_negate(64'(q_q))) : q_q;
        remainder_d = sign_r_q ? WIDTH'(div_negate(64'(p_q))) : p_q[WIDTH-1:0];
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mag_n_q     <= {WIDTH{1'b0}};
      mag_d_q     <= {WIDTH{1'b0}};
      sign_q_q    <= 1'b0;
      sign_r_q    <= 1'b0;
      p_q         <= {(WIDTH+1){1'b0}};
      q_q         <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_n_q     <= mag_n_d;
      mag_d_q     <= mag_d_d;
      sign_q_q    <= sign_q_d;
      sign_r_q    <= sign_r_d;
      p_q         <= p_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
